// File: rtl/clk_div_ctrl_pkg.sv
// clk_div_ctrl_pkg: shared types and defaults for the clock-divider
// reconfiguration controller.
//   clk_div_ctrl_state_e : controller FSM states
//   DEF_GATE_CYCLES      : default gate-off window before divider reset
//   DEF_SETTLE_CYCLES    : default settle window after divider reset
//   max2()               : helper used to size the shared timer
package clk_div_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    GATE   = 2'd1,
    HOLD   = 2'd2,
    SETTLE = 2'd3
  } clk_div_ctrl_state_e;

  localparam int DEF_GATE_CYCLES   = 2;
  localparam int DEF_SETTLE_CYCLES = 4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clk_div_ctrl_timer.sv
// clk_div_ctrl_timer: loadable down-counter that parks at zero.
//   clk_i      : clock
//   srst_i     : synchronous active-high reset (count -> 0)
//   load_i     : load load_val_i this cycle (wins over decrement)
//   load_val_i : value to load
//   zero_o     : count is zero
module clk_div_ctrl_timer #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         srst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (srst_i)          cnt <= '0;
    else if (load_i)     cnt <= load_val_i;
    else if (cnt != '0)  cnt <= cnt - W'(1);
  end

  assign zero_o = (cnt == '0);

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: sequences a glitch-free divisor change on a clk_div
// instance: gate the divided clock, pulse the divider reset while the new
// divisor is applied, wait a settle window, then ungate.
//   clk_i        : divider source clock
//   srst_i       : synchronous active-high reset
//   cfg_div_i    : requested divisor
//   cfg_valid_i  : request valid (held by requester until accepted)
//   cfg_ready_o  : request can be accepted (RUN only)
//   cfg_done_o   : one-cycle pulse when a request completes
//   div_o        : divisor to the divider
//   div_rst_o    : active-high divider reset
//   gate_en_o    : downstream clock gate enable
//   busy_o       : sequence in progress
//   change_cnt_o : saturating count of completed requests
//                  (only with CLK_DIV_CTRL_CHANGE_CNT_EN defined)
// All outputs come from registers or decoded registered state.
module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int DIV_WIDTH     = 4,
  parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int RESET_DIV     = 0
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  output logic                 cfg_done_o,
  output logic [DIV_WIDTH-1:0] div_o,
  output logic                 div_rst_o,
  output logic                 gate_en_o,
  output logic                 busy_o
`ifdef CLK_DIV_CTRL_CHANGE_CNT_EN
  ,
  output logic [15:0]          change_cnt_o
`endif
);

  localparam int TW = $clog2(max2(GATE_CYCLES, SETTLE_CYCLES) + 1);
  localparam logic [TW-1:0] GATE_LD   = TW'(GATE_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYCLES - 1);

  if (GATE_CYCLES < 1) begin : g_bad_gate
    $error("clk_div_ctrl: GATE_CYCLES must be >= 1");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("clk_div_ctrl: SETTLE_CYCLES must be >= 1");
  end
  if (RESET_DIV < 0 || RESET_DIV >= (1 << DIV_WIDTH)) begin : g_bad_rdiv
    $error("clk_div_ctrl: RESET_DIV out of range");
  end

  clk_div_ctrl_state_e state, state_n;
  logic [DIV_WIDTH-1:0] pending;
  logic                 accept, t_load, t_zero, done_n;
  logic [TW-1:0]        t_val;

  assign accept = cfg_valid_i && (state == RUN);

  clk_div_ctrl_timer #(.W(TW)) u_timer (
    .clk_i      (clk_i),
    .srst_i     (srst_i),
    .load_i     (t_load),
    .load_val_i (t_val),
    .zero_o     (t_zero)
  );

  always_ff @(posedge clk_i) begin
    if (srst_i) state <= RUN;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    t_load  = 1'b0;
    t_val   = '0;
    done_n  = 1'b0;
    case (state)
      RUN: begin
        if (accept) begin
          // A same-value request completes immediately without gating.
          if (cfg_div_i == div_o) begin
            done_n = 1'b1;
          end else begin
            state_n = GATE;
            t_load  = 1'b1;
            t_val   = GATE_LD;
          end
        end
      end
      GATE:   if (t_zero) state_n = HOLD;
      HOLD: begin
        state_n = SETTLE;
        t_load  = 1'b1;
        t_val   = SETTLE_LD;
      end
      SETTLE: begin
        if (t_zero) begin
          state_n = RUN;
          done_n  = 1'b1;
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      pending    <= '0;
      div_o      <= DIV_WIDTH'(RESET_DIV);
      cfg_done_o <= 1'b0;
    end else begin
      if (accept) pending <= cfg_div_i;
      // New divisor lands on HOLD entry, i.e. while the divider is in reset.
      if (state == GATE && state_n == HOLD) div_o <= pending;
      cfg_done_o <= done_n;
    end
  end

  assign cfg_ready_o = (state == RUN);
  assign busy_o      = (state != RUN);
  assign gate_en_o   = (state == RUN);
  assign div_rst_o   = (state == HOLD);

`ifdef CLK_DIV_CTRL_CHANGE_CNT_EN
  always_ff @(posedge clk_i) begin
    if (srst_i)                                 change_cnt_o <= '0;
    else if (done_n && change_cnt_o != 16'hFFFF) change_cnt_o <= change_cnt_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: self-checking bench for clk_div_ctrl (default parameters).
// Table-driven 0->5 change, hand sequences for same-value, back-to-back and
// reset mid-settle, then random traffic against a timeline reference model.
module tb_clk_div_ctrl;

  localparam int G = 2;
  localparam int S = 4;

  logic       clk = 1'b0;
  logic       srst, cfg_valid;
  logic [3:0] cfg_div;
  logic       ready, done, drst, gate, busy;
  logic [3:0] dv;
`ifdef CLK_DIV_CTRL_CHANGE_CNT_EN
  logic [15:0] change_cnt;
`endif

  always #5 clk = ~clk;

  clk_div_ctrl dut (
    .clk_i       (clk),
    .srst_i      (srst),
    .cfg_div_i   (cfg_div),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (ready),
    .cfg_done_o  (done),
    .div_o       (dv),
    .div_rst_o   (drst),
    .gate_en_o   (gate),
    .busy_o      (busy)
`ifdef CLK_DIV_CTRL_CHANGE_CNT_EN
    ,
    .change_cnt_o(change_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_ready, input logic e_done,
                         input logic [3:0] e_div, input logic e_rst, input logic e_gate,
                         input logic e_busy);
    chk({tag, ".ready"}, 32'(ready), 32'(e_ready));
    chk({tag, ".done"},  32'(done),  32'(e_done));
    chk({tag, ".div"},   32'(dv),    32'(e_div));
    chk({tag, ".rst"},   32'(drst),  32'(e_rst));
    chk({tag, ".gate"},  32'(gate),  32'(e_gate));
    chk({tag, ".busy"},  32'(busy),  32'(e_busy));
  endtask

  // Reference model: a request is a timeline anchored at its accept cycle t0.
  // Cycle offset k = cyc - t0: busy for 1..G+S+1, divider reset and new
  // divisor at k = G+1, done at k = G+S+2.
  int         cyc = 0, t0 = -1, done_at = -1;
  logic [3:0] m_div = 4'd0, m_new = 4'd0;
  logic [15:0] m_cnt = 16'd0;

  function automatic bit m_busy();
    return (t0 >= 0) && (cyc - t0 >= 1) && (cyc - t0 <= G + S + 1);
  endfunction
  function automatic bit m_done();
    return (cyc == done_at) || ((t0 >= 0) && (cyc - t0 == G + S + 2));
  endfunction
  function automatic bit m_rst();
    return (t0 >= 0) && (cyc - t0 == G + 1);
  endfunction

  task automatic model_edge();
    if (srst) begin
      t0 = -1; done_at = -1; m_div = 4'd0;
    end else if (!m_busy() && cfg_valid) begin
      if (cfg_div == m_div) done_at = cyc + 1;
      else begin t0 = cyc; m_new = cfg_div; end
    end
    cyc++;
    if (!srst && m_rst()) m_div = m_new;
    if (srst) m_cnt = 16'd0;
    else if (m_done() && m_cnt != 16'hFFFF) m_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk_all(tag, !m_busy(), m_done(), m_div, m_rst(), !m_busy(), m_busy());
`ifdef CLK_DIV_CTRL_CHANGE_CNT_EN
    chk({tag, ".cnt"}, 32'(change_cnt), 32'(m_cnt));
`endif
  endtask

  typedef struct {
    logic       srst, valid;
    logic [3:0] din;
    logic       ready, done;
    logic [3:0] dv;
    logic       drst, gate, busy;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Row i: expected outputs in cycle i, then inputs driven during cycle i.
    tbl[0] = '{0, 1, 4'd5, 1, 0, 4'd0, 0, 1, 0};
    tbl[1] = '{0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 1};
    tbl[2] = '{0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 1};
    tbl[3] = '{0, 0, 4'd0, 0, 0, 4'd5, 1, 0, 1};
    tbl[4] = '{0, 0, 4'd0, 0, 0, 4'd5, 0, 0, 1};
    tbl[5] = '{0, 0, 4'd0, 0, 0, 4'd5, 0, 0, 1};
    tbl[6] = '{0, 0, 4'd0, 0, 0, 4'd5, 0, 0, 1};
    tbl[7] = '{0, 0, 4'd0, 0, 0, 4'd5, 0, 0, 1};
    tbl[8] = '{0, 0, 4'd0, 1, 1, 4'd5, 0, 1, 0};
    tbl[9] = '{0, 0, 4'd0, 1, 0, 4'd5, 0, 1, 0};

    srst = 1'b1; cfg_valid = 1'b0; cfg_div = 4'd0;
    repeat (3) tick();
    srst = 1'b0;
    chk_all("reset", 1, 0, 4'd0, 0, 1, 0);

    // 0 -> 5 change
    for (int i = 0; i < 10; i++) begin
      chk_all($sformatf("tbl%0d", i), tbl[i].ready, tbl[i].done, tbl[i].dv,
              tbl[i].drst, tbl[i].gate, tbl[i].busy);
      srst = tbl[i].srst; cfg_valid = tbl[i].valid; cfg_div = tbl[i].din;
      tick();
    end

    // same value: no gating, done the cycle after acceptance
    cfg_valid = 1'b1; cfg_div = 4'd5;
    tick();
    cfg_valid = 1'b0;
    chk_all("same1", 1, 1, 4'd5, 0, 1, 0);
    tick();
    chk_all("same2", 1, 0, 4'd5, 0, 1, 0);

    // back-to-back: 5 -> 0 then 9 held until accepted
    cfg_valid = 1'b1; cfg_div = 4'd0;
    tick();                              // cycle 1
    cfg_div = 4'd9;
    for (int c = 1; c < 8; c++) begin
      chk($sformatf("b2b_ready_c%0d", c), 32'(ready), 32'd0);
      tick();
    end
    chk_all("b2b_c8", 1, 1, 4'd0, 0, 1, 0);
    tick();                              // 9 accepted at edge 8
    cfg_valid = 1'b0;
    tick(); tick();                      // cycle 11
    chk_all("b2b_c11", 0, 0, 4'd9, 1, 0, 1);
    repeat (5) tick();                   // cycle 16
    chk_all("b2b_c16", 1, 1, 4'd9, 0, 1, 0);

    // reset mid-SETTLE: 9 -> 3 first, then request 7, srst in cycle 5
    cfg_valid = 1'b1; cfg_div = 4'd3;
    tick(); cfg_valid = 1'b0;
    repeat (8) tick();
    chk("mid_pre_div", 32'(dv), 32'd3);
    cfg_valid = 1'b1; cfg_div = 4'd7;
    tick(); cfg_valid = 1'b0;            // cycle 1
    repeat (4) tick();                   // cycle 5 (SETTLE)
    chk("mid_c5_busy", 32'(busy), 32'd1);
    srst = 1'b1;
    tick();                              // cycle 6
    srst = 1'b0;
    chk_all("mid_c6", 1, 0, 4'd0, 0, 1, 0);
    for (int c = 7; c < 11; c++) begin
      tick();
      chk($sformatf("mid_nodone_c%0d", c), 32'(done), 32'd0);
    end

    // pass-through divisor 0 from a nonzero value is sequenced normally
    cfg_valid = 1'b1; cfg_div = 4'd6;
    tick(); cfg_valid = 1'b0;
    repeat (8) tick();
    cfg_valid = 1'b1; cfg_div = 4'd0;
    tick(); cfg_valid = 1'b0;
    chk("zero_gate", 32'(gate), 32'd0);
    tick(); tick();
    chk_all("zero_hold", 0, 0, 4'd0, 1, 0, 1);

    // random traffic against the timeline model
    srst = 1'b1; tick(); srst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      chk_model($sformatf("rnd%0d", n));
      srst      = ($urandom_range(0, 99) == 0);
      cfg_valid = $urandom_range(0, 1) == 1;
      cfg_div   = ($urandom_range(0, 3) == 0) ? m_div : 4'($urandom_range(0, 15));
      tick();
    end
    chk_model("rnd_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
